seven_segment_scan_driver: RTL and testbench

//   Time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/seven_seg_glyph_rom.sv | 19 +
 rtl/seven_segment_scan_driver.sv | 216 +++++++++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared glyph table, scan phase type and dwell helper for the
//               seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] c_GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h5F, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int dwell_cycles(input int clk_hz, input int refresh_hz,
                                        input int n_digits);
        return clk_hz / (refresh_hz * n_digits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_glyph_rom.sv
// ============================================================================
// Module      : seven_seg_glyph_rom
// Description : Combinational hex nibble to active-high segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_glyph_rom
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = c_GLYPH_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seven_segment_scan_driver.sv
// ============================================================================
// Module      : seven_segment_scan_driver
// Description : Time-multiplexed N-digit seven-segment driver with blanking,
//               double-buffered input, digit enables, dp and zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int CLK_HZ         = 100_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_suppress,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int c_DWELL     = dwell_cycles(CLK_HZ, REFRESH_HZ, N_DIGITS);
    localparam int c_CW        = (c_DWELL > 1) ? $clog2(c_DWELL) : 1;
    localparam int c_IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_ON_CYCLES = c_DWELL - BLANK_CYCLES;

    localparam logic [c_CW-1:0]     c_BLANK_LAST = c_CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_CW-1:0]     c_ON_LAST    = c_CW'((c_ON_CYCLES > 0) ? c_ON_CYCLES - 1 : 0);
    localparam logic [c_IW-1:0]     c_LAST_IDX   = c_IW'(N_DIGITS - 1);
    localparam logic [6:0]          c_SEG_DARK   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                c_DP_DARK    = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] c_AN_DARK    = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
        $error("seven_segment_scan_driver: N_DIGITS must be 1..8");
    end
    if (c_DWELL < BLANK_CYCLES + 1) begin : g_bad_dwell
        $error("seven_segment_scan_driver: dwell too short for BLANK_CYCLES");
    end

    phase_e                phase_q, phase_d;
    logic [c_IW-1:0]       idx_q, idx_d;
    logic [c_CW-1:0]       cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;

    logic [4*N_DIGITS-1:0] pend_val_q, disp_val_q;
    logic [N_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic [N_DIGITS-1:0]   pend_en_q, disp_en_q;
    logic                  pend_lz_q, disp_lz_q;
    logic                  pend_valid_q;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_tick_q;

    logic                  w_swap;
    logic                  w_zero_run;
    logic [N_DIGITS-1:0]   w_supp;
    logic [3:0]            w_nib;
    logic [6:0]            w_glyph;
    logic                  w_lit;
    logic [N_DIGITS-1:0]   w_onehot;

    // ---------------- scan state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + c_CW'(1);
        wrap_d  = 1'b0;
        case (phase_q)
            PH_BLANK: begin
                if (cnt_q == c_BLANK_LAST) begin
                    phase_d = PH_ON;
                    cnt_d   = '0;
                end
            end
            PH_ON: begin
                if (cnt_q == c_ON_LAST) begin
                    phase_d = PH_BLANK;
                    cnt_d   = '0;
                    if (idx_q == c_LAST_IDX) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + c_IW'(1);
                    end
                end
            end
            default: begin
                phase_d = PH_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer swap happens as digit 0 enters its lit phase so a frame never tears
    assign w_swap = (phase_q == PH_BLANK) && (phase_d == PH_ON) && (idx_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            disp_lz_q    <= 1'b0;
        end else begin
            if (load && !w_swap) begin
                pend_val_q   <= value;
                pend_dp_q    <= dp_in;
                pend_en_q    <= digit_en;
                pend_lz_q    <= lz_suppress;
                pend_valid_q <= 1'b1;
            end else if (w_swap) begin
                pend_valid_q <= 1'b0;
            end

            if (w_swap && load) begin
                disp_val_q <= value;
                disp_dp_q  <= dp_in;
                disp_en_q  <= digit_en;
                disp_lz_q  <= lz_suppress;
            end else if (w_swap && pend_valid_q) begin
                disp_val_q <= pend_val_q;
                disp_dp_q  <= pend_dp_q;
                disp_en_q  <= pend_en_q;
                disp_lz_q  <= pend_lz_q;
            end
        end
    end

    // A digit is suppressed while it and every digit above it are zero
    always_comb begin
        w_zero_run = 1'b1;
        w_supp     = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (disp_val_q[4*i +: 4] == 4'h0);
            w_supp[i]  = disp_lz_q && w_zero_run;
        end
    end

    assign w_nib    = disp_val_q[{idx_q, 2'b00} +: 4];
    assign w_lit    = disp_en_q[idx_q] && !w_supp[idx_q];
    assign w_onehot = N_DIGITS'(1) << idx_q;

    seven_seg_glyph_rom u_glyph_rom (
        .nibble_i (w_nib),
        .glyph_o  (w_glyph)
    );

    // ---------------- output logic ----------------
    always_comb begin
        seg_d = c_SEG_DARK;
        dp_d  = c_DP_DARK;
        an_d  = c_AN_DARK;
        if (phase_q == PH_ON) begin
            an_d = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
            if (w_lit) begin
                seg_d = SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
                dp_d  = SEG_ACTIVE_LOW ? ~disp_dp_q[idx_q] : disp_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= c_SEG_DARK;
            dp_q         <= c_DP_DARK;
            an_q         <= c_AN_DARK;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= wrap_q;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
// ============================================================================
// Module      : tb_seven_segment_scan_driver
// Description : Self-checking bench; reference model works on frame positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_driver;

    localparam int N     = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DWELL;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h5F, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int pos      = 0;

    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp, m_en, p_en;
    logic        m_lz, p_lz, p_v;

    seven_segment_scan_driver #(
        .N_DIGITS       (N),
        .CLK_HZ         (3200),
        .REFRESH_HZ     (100),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .load        (load),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, pos, obs, exp);
        end
    endtask

    task automatic reset_model();
        pos   = 0;
        m_val = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
        p_val = '0; p_dp = '0; p_en = '0; p_lz = 1'b0; p_v = 1'b0;
    endtask

    // One clock: predict outputs for the slot position just ended, then update buffers
    task automatic tick();
        int         p, off, slot;
        logic [6:0] e_seg;
        logic       e_dp, e_ft, lit, swap;
        logic [3:0] e_an, nib;
        @(posedge clk);
        p    = pos;
        pos  = pos + 1;
        off  = p % DWELL;
        slot = (p / DWELL) % N;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_an  = 4'hF;
        e_ft  = (p % FRAME == 0) && (p != 0);
        if (off >= BLANK) begin
            e_an = 4'hF ^ (4'b0001 << slot);
            nib  = 4'((m_val >> (4 * slot)) & 16'h000F);
            lit  = m_en[slot] && !(m_lz && slot != 0 && (m_val >> (4 * slot)) == 16'h0);
            if (lit) begin
                e_seg = ~GLYPH[nib];
                e_dp  = ~m_dp[slot];
            end
        end
        swap = (p % FRAME == BLANK - 1);
        if (load) begin
            if (swap) begin
                m_val = value; m_dp = dp_in; m_en = digit_en; m_lz = lz_suppress;
                p_v = 1'b0;
            end else begin
                p_val = value; p_dp = dp_in; p_en = digit_en; p_lz = lz_suppress;
                p_v = 1'b1;
            end
        end else if (swap && p_v) begin
            m_val = p_val; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
            p_v = 1'b0;
        end
        #1;
        check("seg", {9'd0, seg}, {9'd0, e_seg});
        check("dp", {15'd0, dp}, {15'd0, e_dp});
        check("an", {12'd0, an}, {12'd0, e_an});
        check("frame_tick", {15'd0, frame_tick}, {15'd0, e_ft});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e, input logic lz);
        value = v; dp_in = d; digit_en = e; lz_suppress = lz;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic load_at(input int fp, input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e, input logic lz);
        while (pos % FRAME != fp) tick();
        do_load(v, d, e, lz);
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"}, {9'd0, seg}, 16'h007F);
        check({tag, "_dp"}, {15'd0, dp}, 16'h0001);
        check({tag, "_an"}, {12'd0, an}, 16'h000F);
        check({tag, "_ft"}, {15'd0, frame_tick}, 16'h0000);
    endtask

    initial begin
        logic [15:0] mask;
        rst_n = 1'b0; value = '0; dp_in = '0; digit_en = '0; lz_suppress = 1'b0; load = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(40);
        do_load(16'h1234, 4'h0, 4'hF, 1'b0);
        run(80);
        do_load(16'h0050, 4'h0, 4'hF, 1'b1);
        run(70);
        do_load(16'h0000, 4'h0, 4'hF, 1'b1);
        run(70);
        load_at(12, 16'hABCD, 4'h0, 4'hF, 1'b0);
        run(60);
        load_at(1, 16'h5E0F, 4'h0, 4'hF, 1'b1);
        run(40);
        do_load(16'h8888, 4'b0001, 4'b0101, 1'b0);
        run(70);
        do_load(16'h1111, 4'hF, 4'hF, 1'b0);
        do_load(16'h9C7A, 4'b1010, 4'hF, 1'b0);
        run(70);

        // asynchronous reset in the middle of a lit slot
        load_at(20, 16'h4321, 4'hF, 4'hF, 1'b0);
        run(40);
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_reset");
        @(negedge clk);
        reset_model();
        rst_n = 1'b1;
        run(40);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                3:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            if ($urandom_range(0, 3) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            load_at($urandom_range(0, FRAME - 1), 16'($urandom) & mask,
                    4'($urandom), 4'($urandom), 1'($urandom));
            run($urandom_range(5, 50));
        end
        run(FRAME + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
